// File: rtl/block_mem_responder_if.sv
// rtl/block_mem_responder_if.sv - cache-to-memory block request/response channel
interface block_mem_responder_if;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [9:0]   req_addr;
  logic [9:0]   req_wb_addr;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_rdata;
  logic         resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wb_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wb_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/block_mem_responder.sv
// rtl/block_mem_responder.sv - latency-modelling main-memory block responder
module block_mem_responder #(
  parameter int LATENCY = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  block_mem_responder_if.slave        bus,
  output logic [15:0]                 rd_count,
  output logic [15:0]                 wr_count
);

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_WBF   = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic [1:0]    op_q;
  logic [5:0]    fill_blk;
  logic [5:0]    wb_blk;
  logic [127:0]  wdata_q;
  logic          err_q;
  logic          accept;
  logic          commit;
  logic          capture;
  logic          cnt_zero;

  // Zero at power-up, never cleared by reset.
  logic [31:0]   mem [256] = '{default: '0};

  // Offset bits inside a block carry no meaning here.
  logic          unused_bits;
  assign unused_bits = ^{bus.req_addr[3:0], bus.req_wb_addr[3:0]};

  assign cnt_zero     = (cnt == 4'd0);
  assign bus.resp_err = (state == RESP) && err_q;

  // State register; reset abandons whatever operation is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, handshake outputs and one-cycle memory strobes.
  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    commit         = 1'b0;
    capture        = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept = 1'b1;
          // An illegal op takes one pass through RD with no access so its
          // error response lands one cycle after accept.
          if (bus.req_op == OP_WRITE || bus.req_op == OP_WBF) state_nxt = WR;
          else                                                 state_nxt = RD;
        end
      end
      WR: begin
        if (cnt_zero) begin
          commit    = 1'b1;
          state_nxt = (op_q == OP_WBF) ? RD : RESP;
        end
      end
      RD: begin
        if (cnt_zero) begin
          capture   = !err_q;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, latency counter, response data and activity counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= 4'd0;
      op_q           <= OP_READ;
      fill_blk       <= 6'd0;
      wb_blk         <= 6'd0;
      wdata_q        <= '0;
      err_q          <= 1'b0;
      bus.resp_rdata <= '0;
      rd_count       <= 16'd0;
      wr_count       <= 16'd0;
    end else begin
      if (accept) begin
        op_q     <= bus.req_op;
        fill_blk <= bus.req_addr[9:4];
        wb_blk   <= bus.req_wb_addr[9:4];
        wdata_q  <= bus.req_wdata;
        err_q    <= (bus.req_op == OP_ILL);
        cnt      <= (bus.req_op == OP_ILL) ? 4'd0 : CNT_LOAD;
      end else if (commit && op_q == OP_WBF) begin
        cnt <= CNT_LOAD;
      end else if ((state == WR || state == RD) && !cnt_zero) begin
        cnt <= cnt - 4'd1;
      end

      if (commit) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        if (op_q == OP_WRITE) bus.resp_rdata <= wdata_q;
      end

      if (capture) begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        bus.resp_rdata <= {mem[{fill_blk, 2'd0}], mem[{fill_blk, 2'd1}],
                           mem[{fill_blk, 2'd2}], mem[{fill_blk, 2'd3}]};
      end
    end
  end

  // Block write into the victim block; word 0 comes from the top of wdata.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int k = 0; k < 4; k++) begin
        mem[{wb_blk, 2'(k)}] <= wdata_q[127 - 32*k -: 32];
      end
    end
  end

endmodule

// File: tb/tb_block_mem_responder.sv
// tb/tb_block_mem_responder.sv - self-checking bench for block_mem_responder
module tb_block_mem_responder;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  block_mem_responder_if bus ();

  block_mem_responder #(.LATENCY(LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem [256];
  int          ref_rd = 0;
  int          ref_wr = 0;

  typedef struct {
    logic [1:0]   op;
    logic [9:0]   addr;
    logic [9:0]   wb;
    logic [127:0] wd;
    int           lat;
    logic [127:0] rdata;
    logic         err;
  } vec_t;

  vec_t vecs [9];

  localparam logic [127:0] W1 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] W2 = 128'hDEADBEEF_00000000_00000000_CAFEF00D;
  localparam logic [127:0] W3 = 128'h0F0F0F0F_A5A5A5A5_12345678_9ABCDEF0;
  localparam logic [127:0] W4 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] W5 = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural memory: writes land before the fill read of the same request.
  task automatic model(input logic [1:0] op, input logic [9:0] a, input logic [9:0] wb,
                       input logic [127:0] wd, output int lat, output logic [127:0] rd,
                       output logic err);
    int wbase, fbase;
    wbase = int'(wb[9:4]) * 4;
    fbase = int'(a[9:4]) * 4;
    err = 1'b0; rd = '0; lat = LAT;
    if (op == 2'd3) begin
      err = 1'b1; lat = 1;
      return;
    end
    if (op != 2'd0) begin
      for (int k = 0; k < 4; k++) ref_mem[wbase + k] = wd[127 - 32*k -: 32];
      if (ref_wr < 65535) ref_wr++;
    end
    if (op == 2'd1) begin
      rd = wd;
    end else begin
      for (int k = 0; k < 4; k++) rd[127 - 32*k -: 32] = ref_mem[fbase + k];
      if (ref_rd < 65535) ref_rd++;
    end
    if (op == 2'd2) lat = 2 * LAT;
  endtask

  task automatic do_req(input string nm, input logic [1:0] op, input logic [9:0] a,
                        input logic [9:0] wb, input logic [127:0] wd, input int exp_lat,
                        input logic [127:0] exp_rd, input logic exp_err, input int stall,
                        input bit pulse);
    int cyc;
    logic [127:0] held;
    @(negedge clk);
    chk({nm, " req_ready"}, 128'(bus.req_ready), 128'd1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a;
    bus.req_wb_addr = wb; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op = 2'($urandom); bus.req_addr = 10'($urandom);
    bus.req_wb_addr = 10'($urandom); bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
    cyc = 0;
    while (!bus.resp_valid && cyc < 64) begin
      @(posedge clk); #1; cyc++;
    end
    chk({nm, " latency"}, 128'(cyc), 128'(exp_lat));
    chk({nm, " err"}, 128'(bus.resp_err), 128'(exp_err));
    if (!exp_err) chk({nm, " rdata"}, bus.resp_rdata, exp_rd);
    chk({nm, " rd_count"}, 128'(rd_count), 128'(ref_rd));
    chk({nm, " wr_count"}, 128'(wr_count), 128'(ref_wr));
    held = bus.resp_rdata;
    if (pulse) begin
      bus.req_op = 2'd1; bus.req_wb_addr = 10'h3F0; bus.req_wdata = W5;
    end
    for (int i = 0; i < stall; i++) begin
      bus.req_valid = pulse && (i == 1);
      @(posedge clk); #1;
      chk({nm, " hold valid"}, 128'(bus.resp_valid), 128'd1);
      chk({nm, " hold rdata"}, bus.resp_rdata, held);
      chk({nm, " hold ready"}, 128'(bus.req_ready), 128'd0);
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk({nm, " valid drop"}, 128'(bus.resp_valid), 128'd0);
    chk({nm, " err drop"}, 128'(bus.resp_err), 128'd0);
  endtask

  task automatic run_model_req(input string nm, input logic [1:0] op, input logic [9:0] a,
                               input logic [9:0] wb, input logic [127:0] wd,
                               input int stall, input bit pulse);
    int lat; logic [127:0] rd; logic err;
    model(op, a, wb, wd, lat, rd, err);
    do_req(nm, op, a, wb, wd, lat, rd, err, stall, pulse);
  endtask

  initial begin
    int lat; logic [127:0] rd; logic err;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_addr = '0;
    bus.req_wb_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;

    vecs[0] = '{2'd0, 10'h040, 10'h000, '0, LAT,     '0, 1'b0};
    vecs[1] = '{2'd1, 10'h000, 10'h0A0, W1, LAT,     W1, 1'b0};
    vecs[2] = '{2'd0, 10'h0AC, 10'h000, '0, LAT,     W1, 1'b0};
    vecs[3] = '{2'd2, 10'h200, 10'h100, W2, 2 * LAT, '0, 1'b0};
    vecs[4] = '{2'd0, 10'h100, 10'h000, '0, LAT,     W2, 1'b0};
    vecs[5] = '{2'd3, 10'h0A0, 10'h0A0, W4, 1,       '0, 1'b1};
    vecs[6] = '{2'd0, 10'h0A0, 10'h000, '0, LAT,     W1, 1'b0};
    vecs[7] = '{2'd1, 10'h3FF, 10'h0F0, W3, LAT,     W3, 1'b0};
    vecs[8] = '{2'd2, 10'h30C, 10'h300, W4, 2 * LAT, W4, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 128'(bus.req_ready), 128'd1);
    chk("reset resp_valid", 128'(bus.resp_valid), 128'd0);
    chk("reset resp_err", 128'(bus.resp_err), 128'd0);
    chk("reset resp_rdata", bus.resp_rdata, 128'd0);
    chk("reset rd_count", 128'(rd_count), 128'd0);
    chk("reset wr_count", 128'(wr_count), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      model(vecs[i].op, vecs[i].addr, vecs[i].wb, vecs[i].wd, lat, rd, err);
      do_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wb, vecs[i].wd,
             vecs[i].lat, vecs[i].rdata, vecs[i].err, 0, 1'b0);
    end

    // Stalled response with a stray request pulse that must be dropped.
    run_model_req("stall", 2'd0, 10'h0A4, 10'h000, '0, 5, 1'b1);
    repeat (8) begin
      @(posedge clk); #1;
      chk("stray no resp", 128'(bus.resp_valid), 128'd0);
    end
    chk("stray wr_count", 128'(wr_count), 128'(ref_wr));
    run_model_req("stray read", 2'd0, 10'h3F0, 10'h000, '0, 0, 1'b0);

    // Reset in the middle of a write leaves the old block in memory.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 2'd1; bus.req_wb_addr = 10'h0F0; bus.req_wdata = W5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    ref_rd = 0; ref_wr = 0;
    chk("midrst req_ready", 128'(bus.req_ready), 128'd1);
    chk("midrst resp_valid", 128'(bus.resp_valid), 128'd0);
    chk("midrst resp_rdata", bus.resp_rdata, 128'd0);
    chk("midrst rd_count", 128'(rd_count), 128'd0);
    chk("midrst wr_count", 128'(wr_count), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_model_req("after rst", 2'd0, 10'h0F0, 10'h000, '0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_model_req($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 10'($urandom),
                    10'($urandom), {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 3), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
